// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter (MIN_VAL..MIN_VAL+MODULUS-1) with set-mode key auto-repeat.
// Optional macro BCD_MOD_COUNTER_DEC_EN enables the DEC key (step -1 through the same FSM).
module bcd_mod_counter #(
  parameter int MODULUS       = 24,
  parameter int MIN_VAL       = 0,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       CARRY_IN,
  input  logic [1:0] SET_STATE,
  input  logic       INC,
  input  logic       DEC,
  output logic [3:0] CNT_H,
  output logic [3:0] CNT_L,
  output logic       CARRY_OUT
);
  localparam int MAX_VAL = MIN_VAL + MODULUS - 1;
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [7:0] MIN_BCD = {4'(MIN_VAL / 10), 4'(MIN_VAL % 10)};
  localparam logic [7:0] MAX_BCD = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};
  if (MODULUS < 2 || MODULUS > 99 || (MIN_VAL != 0 && MIN_VAL != 1) || MAX_VAL > 99 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("bcd_mod_counter: illegal parameter set");
  end
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, lim;
  logic [7:0]      cnt_q, cnt_d, up;
  logic            inc_prev_q, inc_arm_q;
  logic            run, set, at_max, step, down;
  logic            dec_k, dec_rise, dir, inc_rise, key_k, other_k;
  assign run      = SET_STATE == 2'b01;
  assign set      = SET_STATE == 2'b10;
  assign at_max   = cnt_q == MAX_BCD;
  assign CARRY_OUT = run && ENABLE && CARRY_IN && at_max;
  assign CNT_H    = cnt_q[7:4];
  assign CNT_L    = cnt_q[3:0];
  assign up = at_max ? MIN_BCD :
              cnt_q[3:0] == 4'd9 ? {cnt_q[7:4] + 4'd1, 4'd0} : {cnt_q[7:4], cnt_q[3:0] + 4'd1};
  // A key held through reset must be seen low once before it can start a new sequence.
  assign inc_rise = INC && !inc_prev_q && inc_arm_q;
  assign key_k    = dir ? dec_k : INC;
  assign other_k  = dir ? INC : dec_k;
  assign lim      = state_q == HOLD ? TW'(HOLD_CYCLES - 1) : TW'(REPEAT_CYCLES - 1);
`ifdef BCD_MOD_COUNTER_DEC_EN
  logic       dec_prev_q, dec_arm_q, dir_q;
  logic [7:0] dn;
  assign dec_k    = DEC;
  assign dec_rise = DEC && !dec_prev_q && dec_arm_q;
  assign dir      = dir_q;
  assign dn = cnt_q == MIN_BCD ? MAX_BCD :
              cnt_q[3:0] == 4'd0 ? {cnt_q[7:4] - 4'd1, 4'd9} : {cnt_q[7:4], cnt_q[3:0] - 4'd1};
  assign cnt_d = !step ? cnt_q : down ? dn : up;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dec_prev_q <= 1'b0;
      dec_arm_q  <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      dec_prev_q <= DEC;
      dec_arm_q  <= dec_arm_q | ~DEC;
      dir_q      <= state_q == IDLE ? dec_rise : dir_q;
    end
  end
`else
  logic unused_dec;
  assign dec_k      = 1'b0;
  assign dec_rise   = 1'b0;
  assign dir        = 1'b0;
  assign cnt_d      = step ? up : cnt_q;
  assign unused_dec = ^{DEC, down};
`endif
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    step    = 1'b0;
    down    = 1'b0;
    if (run) begin
      state_d = IDLE;
      step    = ENABLE && CARRY_IN;
    end else if (!set) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (!(INC && dec_k) && (inc_rise || dec_rise)) begin
        step    = 1'b1;
        down    = dec_rise;
        state_d = HOLD;
      end
    end else if (!key_k || other_k) state_d = IDLE;
    else if (timer_q == lim) begin
      step    = 1'b1;
      down    = dir;
      state_d = REPEAT;
    end else timer_d = timer_q + TW'(1);
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cnt_q      <= MIN_BCD;
      inc_prev_q <= 1'b0;
      inc_arm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      inc_prev_q <= INC;
      inc_arm_q  <= inc_arm_q | ~INC;
    end
  end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: three counter instances (24/0, 12/1, 60/0) against a value-level reference model.
module tb_bcd_mod_counter;
  localparam int H = 8;
  localparam int R = 4;
`ifdef BCD_MOD_COUNTER_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ci = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [1:0] ss = 2'b00;
  logic [3:0] oh [3];
  logic [3:0] ol [3];
  logic       oc [3];
  int mods [3] = '{24, 12, 60};
  int mins [3] = '{0, 1, 0};
  int v [3];
  int compared = 0, mismatched = 0;
  int t = 0, k = 0;
  bit act, mdir, pinc, pdec, ainc, adec;
  always #5 clk = ~clk;
  bcd_mod_counter #(.MODULUS(24), .MIN_VAL(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u0 (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .CARRY_IN(ci), .SET_STATE(ss), .INC(inc), .DEC(dec),
    .CNT_H(oh[0]), .CNT_L(ol[0]), .CARRY_OUT(oc[0]));
  bcd_mod_counter #(.MODULUS(12), .MIN_VAL(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u1 (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .CARRY_IN(ci), .SET_STATE(ss), .INC(inc), .DEC(dec),
    .CNT_H(oh[1]), .CNT_L(ol[1]), .CARRY_OUT(oc[1]));
  bcd_mod_counter #(.MODULUS(60), .MIN_VAL(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u2 (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .CARRY_IN(ci), .SET_STATE(ss), .INC(inc), .DEC(dec),
    .CNT_H(oh[2]), .CNT_L(ol[2]), .CARRY_OUT(oc[2]));
  function automatic int maxv(int n);
    return mins[n] + mods[n] - 1;
  endfunction
  function automatic logic [7:0] bcd(int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h at t=%0d", tag, got, exp, t);
    end
  endtask
  task automatic check_all();
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("cnt%0d", n), {oh[n], ol[n]}, bcd(v[n]));
      chk($sformatf("carry%0d", n), {7'd0, oc[n]},
          {7'd0, ss == 2'b01 && en && ci && v[n] == maxv(n)});
    end
  endtask
  task automatic model_reset();
    for (int n = 0; n < 3; n++) v[n] = mins[n];
    act = 0; mdir = 0; pinc = 0; pdec = 0; ainc = 0; adec = 0;
  endtask
  task automatic model_edge();
    bit i, d, st, dn, key, oth;
    int dd;
    i = inc; d = DEC_EN ? dec : 1'b0; st = 0; dn = 0;
    if (ss == 2'b01) begin
      act = 0; st = en & ci;
    end else if (ss != 2'b10) act = 0;
    else if (!act) begin
      if (!(i && d)) begin
        if (i && !pinc && ainc) begin st = 1; act = 1; k = t; mdir = 0; end
        else if (d && !pdec && adec) begin st = 1; dn = 1; act = 1; k = t; mdir = 1; end
      end
    end else begin
      key = mdir ? d : i; oth = mdir ? i : d;
      if (!key || oth) act = 0;
      else begin
        dd = t - k;
        if (dd == H || (dd > H && (dd - H) % R == 0)) begin st = 1; dn = mdir; end
      end
    end
    if (st)
      for (int n = 0; n < 3; n++)
        v[n] = dn ? (v[n] == mins[n] ? maxv(n) : v[n] - 1) : (v[n] == maxv(n) ? mins[n] : v[n] + 1);
    pinc = inc; pdec = dec; ainc |= !inc; adec |= !dec;
    t++;
  endtask
  task automatic cycle(logic [1:0] s, logic e, logic c, logic i, logic d);
    ss = s; en = e; ci = c; inc = i; dec = d;
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (23) cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    ss = 2'b01; en = 1'b1; ci = 1'b1;
    #1;
    chk("v24_at_max", {oh[0], ol[0]}, 8'h23);
    chk("co24_at_max", {7'd0, oc[0]}, 8'h01);
    chk("v12_at_max", {oh[1], ol[1]}, 8'h12);
    chk("co12_at_max", {7'd0, oc[1]}, 8'h01);
    chk("co60_mid", {7'd0, oc[2]}, 8'h00);
    cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("v24_wrap", {oh[0], ol[0]}, 8'h00);
    chk("v12_wrap", {oh[1], ol[1]}, 8'h01);
    chk("v60_cont", {oh[2], ol[2]}, 8'h24);
    for (int n = 0; n < 150; n++)
      cycle($urandom_range(9) == 0 ? 2'($urandom_range(3)) : 2'b01,
            $urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
    repeat (20) cycle(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (14) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    begin
      logic ki, kd;
      logic [1:0] s;
      ki = 0; kd = 0; s = 2'b10;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(7) == 0) ki = ~ki;
        if ($urandom_range(11) == 0) kd = ~kd;
        s = $urandom_range(29) == 0 ? 2'($urandom_range(3)) : 2'b10;
        cycle(s, $urandom_range(1), $urandom_range(1), ki, kd);
      end
    end
    cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (15) cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("no_step_after_reset", {oh[0], ol[0]}, 8'h00);
    cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restep_after_reset", {oh[0], ol[0]}, 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter; next-generation successor to the fixed 24-hour clock digit counter.
- Configurable modulus and minimum value, so one block serves the 24-hour, 12-hour, minutes and seconds stages.
- Adds a set-mode key auto-repeat FSM.
- Chained by CARRY_IN/CARRY_OUT inside the clock datapath; digits feed the 7-segment display mux.

Parameters:
- MODULUS, 24, number of distinct values counted (2..99).
- MIN_VAL, 0, lowest value (0 or 1); MAX_VAL = MIN_VAL+MODULUS-1, must be <= 99.
- HOLD_CYCLES, 8, CLK cycles a key must stay held after its first step before auto-repeat starts (>= 1).
- REPEAT_CYCLES, 4, CLK cycles between auto-repeat steps (>= 1).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  one-cycle count tick from the prescaler.
- CARRY_IN  in  1  carry from the lower stage (tie 1 for the lowest stage).
- SET_STATE  in  2  01 = run, 10 = set; 00 and 11 = hold.
- INC  in  1  synchronised, debounced increment key level.
- DEC  in  1  synchronised, debounced decrement key level (used only with the optional feature).
- CNT_H  out  4  tens digit, BCD.
- CNT_L  out  4  units digit, BCD.
- CARRY_OUT  out  1  combinational carry to the next stage.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: {CNT_H,CNT_L} = BCD(MIN_VAL), FSM = IDLE, repeat timer = 0, previous-key registers = 0.
- V = 10*CNT_H + CNT_L. V stays within MIN_VAL..MAX_VAL and both digits are always legal BCD.
- Step +1: if V == MAX_VAL, V becomes MIN_VAL. Otherwise, if CNT_L == 9, CNT_L becomes 0 and CNT_H increments; else CNT_L increments.
- Step -1: if V == MIN_VAL, V becomes MAX_VAL. Otherwise, if CNT_L == 0, CNT_L becomes 9 and CNT_H decrements; else CNT_L decrements.
- Run mode (SET_STATE = 01): step +1 at the edge where ENABLE = 1 and CARRY_IN = 1. Keys are ignored and the FSM is forced to IDLE.
- CARRY_OUT = run mode AND ENABLE AND CARRY_IN AND V == MAX_VAL. It is 0 in every other mode, so set-mode wraps never disturb the upper stage.
- Set mode (SET_STATE = 10): ENABLE and CARRY_IN are ignored. Auto-repeat FSM states: IDLE, HOLD, REPEAT.
  - IDLE: at edge k where a key is sampled high with its previous sample low, step once in that key's direction, clear the timer, go to HOLD.
  - HOLD: timer counts while the key stays high. At edge k+HOLD_CYCLES, step and go to REPEAT with the timer cleared.
  - REPEAT: step at edges k+HOLD_CYCLES+n*REPEAT_CYCLES, n = 1, 2, ...
  - Key released in HOLD or REPEAT: go to IDLE, no step at that edge.
  - INC and DEC both high: no step, FSM goes to IDLE; a new rising edge is needed to restart.
  - Only the key that started the sequence is tracked; the other key rising mid-sequence counts as simultaneous press.
- Leaving set mode or entering hold mid-sequence: FSM goes to IDLE on the next edge and the digits freeze.
- Hold modes 00/11: digits unchanged, FSM IDLE, CARRY_OUT = 0.
- Reset asserted mid-sequence: immediate return to reset values.
- Parameters outside their legal ranges raise an elaboration-time error.

Optional Feature:
- Macro: BCD_MOD_COUNTER_DEC_EN.
- Defined: DEC is active and drives step -1 through the same FSM.
- Not defined: DEC is ignored, so INC=DEC=1 behaves as INC alone; no decrement logic is generated.

Test Plan:
- MODULUS=24, MIN_VAL=0, run, V=23, ENABLE=CARRY_IN=1 for one cycle -> CARRY_OUT=1 that cycle; next state 0,0.
- MODULUS=12, MIN_VAL=1, run, V=09 then 12, with two ticks -> 09 goes to 1,0; 12 goes to 0,1 with CARRY_OUT=1.
- MODULUS=60, set, HOLD_CYCLES=8, REPEAT_CYCLES=4, INC held 20 cycles from V=57 -> steps at edges k, k+8, k+12, k+16 giving 58, 59, 00, 01; CARRY_OUT stays 0.
- Set mode, INC pulsed 1 cycle at V=05 -> exactly one step to 06; FSM back to IDLE.
- With BCD_MOD_COUNTER_DEC_EN, MODULUS=24, V=00, DEC pressed once -> 2,3. Then INC and DEC raised together -> no change.
- RESET_N driven low during REPEAT at V=17, MIN_VAL=0 -> 0,0 immediately; after release with INC still held, no step until INC falls and rises again.
